victim_writeback_buffer: RTL and testbench

Captures elements evicted from a set array's write port and queues them for write-back to the next memory level over a valid/ready channel. Sits beside the cache set RAM: it observes each write the cache controller issues and takes the RAM's evict output one cycle later. Only valid, dirty victims are queued; clean victims are dropped. When the queue is near full it stalls the controller so no victim is lost.

---
 rtl/victim_writeback_buffer_pkg.sv | 16 +
 rtl/victim_writeback_buffer_fifo.sv | 58 +++++
 rtl/victim_writeback_buffer.sv | 132 +++++++++++++
 tb/tb_victim_writeback_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_writeback_buffer_pkg.sv
// rtl/victim_writeback_buffer_pkg.sv - shared element field offsets and queued-entry type
package victim_writeback_buffer_pkg;

  localparam int ELEM_W = 10;
  localparam int SET_W  = 6;

  // Field positions counted down from the element MSB
  localparam int VALID_BIT = 0;
  localparam int DIRTY_BIT = 1;

  typedef struct packed {
    logic [SET_W-1:0]  set_addr;
    logic [ELEM_W-1:0] element;
  } victim_entry_t;

endpackage

// File: rtl/victim_writeback_buffer_fifo.sv
// rtl/victim_writeback_buffer_fifo.sv - victim_fifo: circular queue with exposed storage for lookup
module victim_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [AW-1:0]     rd_ptr_o,
  output logic [AW:0]       count_o,
  output logic [DATA_W-1:0] mem_o [DEPTH]
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign mem_o    = mem_q;

  // The stall rule upstream makes this unreachable; the push is dropped if it happens
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full));

endmodule

// File: rtl/victim_writeback_buffer.sv
// rtl/victim_writeback_buffer.sv - dirty-victim capture, stall and write-back queue
// Optional associative lookup of queued victims when VICTIM_LOOKUP_EN is defined.
module victim_writeback_buffer
  import victim_writeback_buffer_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = ELEM_W,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = SET_W,
  parameter int BUFFER_DEPTH                = 4
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_in,
  output logic                                   stall_out,
  output logic                                   wb_valid_out,
  input  logic                                   wb_ready_in,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       wb_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] wb_element_out,
  input  logic                                   lookup_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       lookup_set_addr_in,
  output logic                                   lookup_hit_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lookup_element_out
);

  localparam int W  = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int SW = SET_PTR_WIDTH_IN_BITS;
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int DW = SW + W;

  generate
    if (NUMBER_SETS > (1 << SW) || BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("victim_writeback_buffer: invalid set or depth configuration");
    end
  endgenerate

  logic          cap_pending_q;
  logic [SW-1:0] cap_addr_q;
  logic          cap_dirty;
  logic          pop;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] mem [BUFFER_DEPTH];
  logic [DW-1:0] head;
  logic [AW+1:0] occupancy;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cap_pending_q <= 1'b0;
      cap_addr_q    <= '0;
    end else begin
      cap_pending_q <= write_en_in;
      cap_addr_q    <= write_set_addr_in;
    end
  end

  assign cap_dirty = cap_pending_q && evict_element_in[W-1-VALID_BIT] && evict_element_in[W-1-DIRTY_BIT];

  victim_fifo #(
    .DEPTH  (BUFFER_DEPTH),
    .DATA_W (DW)
  ) u_fifo (
    .clk_i       (clk_in),
    .rst_i       (reset_in),
    .push_i      (cap_dirty),
    .push_data_i ({cap_addr_q, evict_element_in}),
    .pop_i       (pop),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .mem_o       (mem)
  );

  assign wb_valid_out    = (count != '0);
  assign pop             = wb_valid_out && wb_ready_in;
  assign head            = mem[rd_ptr];
  assign wb_set_addr_out = wb_valid_out ? head[DW-1 -: SW] : '0;
  assign wb_element_out  = wb_valid_out ? head[W-1:0] : '0;

  // Counting the in-flight capture keeps one slot free for it
  assign occupancy = (AW+2)'(count) + (AW+2)'(cap_pending_q);
  assign stall_out = (occupancy >= (AW+2)'(BUFFER_DEPTH - 1));

`ifdef VICTIM_LOOKUP_EN
  logic          lk_hit_q;
  logic [W-1:0]  lk_elem_q;
  logic          lk_hit_d;
  logic [W-1:0]  lk_elem_d;
  logic [AW-1:0] idx;

  // Oldest to youngest so later matches win; the capture stage overrides all
  always_comb begin
    lk_hit_d  = 1'b0;
    lk_elem_d = '0;
    idx       = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if ((AW+1)'(k) < count && mem[idx][DW-1 -: SW] == lookup_set_addr_in) begin
        lk_hit_d  = 1'b1;
        lk_elem_d = mem[idx][W-1:0];
      end
    end
    if (cap_dirty && cap_addr_q == lookup_set_addr_in) begin
      lk_hit_d  = 1'b1;
      lk_elem_d = evict_element_in;
    end
    if (!lookup_en_in) begin
      lk_hit_d  = 1'b0;
      lk_elem_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      lk_hit_q  <= 1'b0;
      lk_elem_q <= '0;
    end else begin
      lk_hit_q  <= lk_hit_d;
      lk_elem_q <= lk_elem_d;
    end
  end

  assign lookup_hit_out     = lk_hit_q;
  assign lookup_element_out = lk_elem_q;
`else
  logic lookup_unused;
  assign lookup_unused      = ^{lookup_en_in, lookup_set_addr_in};
  assign lookup_hit_out     = 1'b0;
  assign lookup_element_out = '0;
`endif

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// tb/tb_victim_writeback_buffer.sv - randomized bench with queue-based reference model
module tb_victim_writeback_buffer;
  import victim_writeback_buffer_pkg::*;

  localparam int W  = 10;
  localparam int SW = 6;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [SW-1:0] waddr = '0;
  logic [W-1:0]  evict = '0;
  logic          ready = 1'b0;
  logic          lk_en = 1'b0;
  logic [SW-1:0] lk_addr = '0;
  logic          stall;
  logic          valid;
  logic [SW-1:0] wb_addr;
  logic [W-1:0]  wb_el;
  logic          lk_hit;
  logic [W-1:0]  lk_el;

  int checks = 0;
  int errors = 0;

  victim_writeback_buffer dut (
    .clk_in             (clk),
    .reset_in           (rst),
    .write_en_in        (we),
    .write_set_addr_in  (waddr),
    .evict_element_in   (evict),
    .stall_out          (stall),
    .wb_valid_out       (valid),
    .wb_ready_in        (ready),
    .wb_set_addr_out    (wb_addr),
    .wb_element_out     (wb_el),
    .lookup_en_in       (lk_en),
    .lookup_set_addr_in (lk_addr),
    .lookup_hit_out     (lk_hit),
    .lookup_element_out (lk_el)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of victims plus the pending capture
  victim_entry_t mq[$];
  victim_entry_t ent;
  bit            m_pend = 0;
  logic [SW-1:0] m_addr = '0;
  bit            e_hit = 0;
  logic [W-1:0]  e_el = '0;
  bit            nh;
  logic [W-1:0]  ne;
  bit            dv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pend = 0;
      m_addr = '0;
      e_hit  = 0;
      e_el   = '0;
    end else begin
      dv = evict[W-1-VALID_BIT] && evict[W-1-DIRTY_BIT];
      nh = 0;
      ne = '0;
`ifdef VICTIM_LOOKUP_EN
      if (lk_en) begin
        if (m_pend && dv && m_addr == lk_addr) begin
          nh = 1;
          ne = evict;
        end else begin
          for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!nh && mq[i].set_addr == lk_addr) begin
              nh = 1;
              ne = mq[i].element;
            end
          end
        end
      end
`endif
      e_hit = nh;
      e_el  = ne;
      if (mq.size() != 0 && ready) void'(mq.pop_front());
      if (m_pend && dv) begin
        ent.set_addr = m_addr;
        ent.element  = evict;
        mq.push_back(ent);
      end
      m_pend = we;
      m_addr = waddr;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("stall", stall, 32'((mq.size() + int'(m_pend)) >= D - 1));
      chk("wb_valid", valid, 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("wb_addr", wb_addr, mq[0].set_addr);
        chk("wb_element", wb_el, mq[0].element);
      end else if (rst) begin
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_element", wb_el, 0);
      end
      chk("lk_hit", lk_hit, e_hit);
      chk("lk_element", lk_el, e_el);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] wr_addrs[$];
  logic [SW-1:0] got[$];
  int            nwr;

  initial begin
    tick();
    tick();
    chk("reset_valid", valid, 0);
    chk("reset_stall", stall, 0);
    chk("reset_addr", wb_addr, 0);
    chk("reset_element", wb_el, 0);
    chk("reset_lk_hit", lk_hit, 0);
    chk("reset_lk_element", lk_el, 0);
    rst = 1'b0;
    tick();

    // Dirty victim: visible two edges after the write
    we = 1'b1; waddr = 6'd5; tick();
    we = 1'b0; evict = 10'h3FF;
    chk("lat1_valid", valid, 0);
    tick();
    chk("lat2_valid", valid, 1);
    chk("lat2_addr", wb_addr, 5);
    chk("lat2_element", wb_el, 10'h3FF);
    ready = 1'b1; tick();
    chk("popped_valid", valid, 0);
    ready = 1'b0; evict = '0;

    // Clean and invalid victims are dropped
    we = 1'b1; waddr = 6'd7; tick();
    waddr = 6'd8; evict = 10'h1FF; tick();
    we = 1'b0; evict = 10'h2AA; tick();
    tick();
    chk("clean_valid", valid, 0);

    // Fill with ready low, writing whenever unstalled
    nwr = 0;
    for (int c = 0; c < 12; c++) begin
      if (!stall) begin
        we = 1'b1;
        waddr = 6'($urandom_range(0, 63));
        wr_addrs.push_back(waddr);
        nwr++;
      end else begin
        we = 1'b0;
      end
      evict = 10'h300 | 10'($urandom_range(0, 255));
      tick();
    end
    we = 1'b0;
    tick();
    chk("fill_writes", nwr, 3);
    chk("fill_stall", stall, 1);
    ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (valid) got.push_back(wb_addr);
      tick();
    end
    chk("drain_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("drain_order", got[i], wr_addrs[i]);

    // Bring count to 2, then push and pop together
    ready = 1'b0;
    we = 1'b1; waddr = 6'd20; evict = 10'h3A0; tick();
    waddr = 6'd21; evict = 10'h3A1; tick();
    we = 1'b0; evict = 10'h3A2; tick();
    chk("cnt2_stall", stall, 0);
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      we = !stall;
      waddr = 6'(22 + c);
      evict = 10'h300 | 10'(c);
      tick();
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      we      = !stall && ($urandom_range(0, 1) == 1);
      waddr   = 6'($urandom_range(0, 7));
      evict   = 10'($urandom);
      ready   = ($urandom_range(0, 2) != 0);
      lk_en   = ($urandom_range(0, 1) == 1);
      lk_addr = 6'($urandom_range(0, 7));
      tick();
    end
    we = 1'b0; lk_en = 1'b0; ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    // Reset while three entries are queued
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      we = 1'b1; waddr = 6'(40 + c); evict = 10'h3F0; tick();
    end
    we = 1'b0; tick();
    chk("pre_rst_valid", valid, 1);
    ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_addr", wb_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0; ready = 1'b0;
    we = 1'b1; waddr = 6'd33; tick();
    we = 1'b0; evict = 10'h3C5; tick();
    chk("post_rst_valid", valid, 1);
    chk("post_rst_addr", wb_addr, 33);
    chk("post_rst_element", wb_el, 10'h3C5);
    ready = 1'b1; tick();
    chk("post_rst_alone", valid, 0);
    ready = 1'b0;

`ifdef VICTIM_LOOKUP_EN
    we = 1'b1; waddr = 6'd9; tick();
    we = 1'b0; evict = 10'h3C1; lk_en = 1'b1; lk_addr = 6'd9; tick();
    chk("lk_capture_hit", lk_hit, 1);
    chk("lk_capture_element", lk_el, 10'h3C1);
    tick();
    chk("lk_queued_hit", lk_hit, 1);
    chk("lk_queued_element", lk_el, 10'h3C1);
    lk_addr = 6'd10; tick();
    chk("lk_miss_hit", lk_hit, 0);
    chk("lk_miss_element", lk_el, 0);
`else
    we = 1'b1; waddr = 6'd9; tick();
    we = 1'b0; evict = 10'h3C1; lk_en = 1'b1; lk_addr = 6'd9; tick();
    tick();
    chk("lk_tied_hit", lk_hit, 0);
    chk("lk_tied_element", lk_el, 0);
`endif
    lk_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
